spi_slave_core: RTL and testbench



---
 rtl/spi_slave_core.sv | 160 ++++++++++++++++
 tb/tb_spi_slave_core.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_core.sv
// SPI target endpoint oversampled in the clk domain: MOSI words out on rx_data/rx_valid,
// words from a one-entry holding buffer shifted out MSB first on MISO.
module spi_slave_core #(
  parameter int REG_WIDTH   = 16,
  parameter int CPOL        = 1,
  parameter int CPHA        = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 SPI_CS_N,
  input  logic                 SPI_SCLK,
  input  logic                 SPI_MOSI,
  output logic                 SPI_MISO,
  output logic                 SPI_MISO_OE,
  input  logic [REG_WIDTH-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [REG_WIDTH-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 tx_underrun,
  output logic                 frame_err
);

  localparam int            CW       = $clog2(REG_WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(REG_WIDTH - 1);
  localparam logic          IDLE_LVL = (CPOL != 0);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT} state_t;

  state_t                state, state_next;
  logic [SYNC_STAGES:0]  sclk_sync, cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                  sclk_cur, sclk_prev, cs_cur, cs_prev, mosi_cur;
  logic                  lead_edge, trail_edge, sample_edge, drive_edge;
  logic                  cs_fall, cs_rise;

  logic                  armed, word_done, first_lead, buf_full;
  logic [REG_WIDTH-1:0]  buf_data, tx_shift, rx_shift;
  logic [CW-1:0]         bit_cnt;

  logic                  load_req, sample_req, shift_req, first_clr, err_req, last_bit;

  // Sync chains clear to 0 so a CS held low through reset never looks like a fresh fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-1:0], SPI_SCLK};
      cs_sync   <= {cs_sync[SYNC_STAGES-1:0], SPI_CS_N};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], SPI_MOSI};
    end
  end

  assign sclk_cur    = sclk_sync[SYNC_STAGES-1];
  assign sclk_prev   = sclk_sync[SYNC_STAGES];
  assign cs_cur      = cs_sync[SYNC_STAGES-1];
  assign cs_prev     = cs_sync[SYNC_STAGES];
  assign mosi_cur    = mosi_sync[SYNC_STAGES-1];
  assign lead_edge   = (sclk_prev == IDLE_LVL) && (sclk_cur != IDLE_LVL);
  assign trail_edge  = (sclk_prev != IDLE_LVL) && (sclk_cur == IDLE_LVL);
  assign sample_edge = (CPHA != 0) ? trail_edge : lead_edge;
  assign drive_edge  = (CPHA != 0) ? lead_edge : trail_edge;
  assign cs_fall     = cs_prev && !cs_cur;
  assign cs_rise     = !cs_prev && cs_cur;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // A CS rise outranks any SCLK edge seen in the same cycle.
  always_comb begin
    state_next = state;
    load_req   = 1'b0;
    sample_req = 1'b0;
    shift_req  = 1'b0;
    first_clr  = 1'b0;
    err_req    = 1'b0;
    last_bit   = 1'b0;
    case (state)
      S_IDLE: begin
        if (cs_fall && armed) state_next = S_LOAD;
      end
      S_LOAD: begin
        load_req   = 1'b1;
        state_next = S_SHIFT;
      end
      S_SHIFT: begin
        if (cs_rise) begin
          state_next = S_IDLE;
          err_req    = (bit_cnt != '0);
        end else if (sample_edge) begin
          sample_req = 1'b1;
          last_bit   = (bit_cnt == LAST_BIT);
        end else if (drive_edge) begin
          if (word_done)                       load_req  = 1'b1;
          else if ((CPHA != 0) && first_lead)  first_clr = 1'b1;
          else                                 shift_req = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed       <= 1'b0;
      word_done   <= 1'b0;
      first_lead  <= 1'b0;
      buf_full    <= 1'b0;
      buf_data    <= '0;
      tx_shift    <= '0;
      rx_shift    <= '0;
      bit_cnt     <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      if (state == S_IDLE && cs_cur) armed <= 1'b1;

      // An in-frame reload stands in for the first leading edge, so it clears first_lead.
      if (load_req) begin
        tx_shift   <= buf_full ? buf_data : '0;
        word_done  <= 1'b0;
        first_lead <= (state == S_LOAD);
      end else if (shift_req) begin
        tx_shift <= {tx_shift[REG_WIDTH-2:0], 1'b0};
      end
      if (first_clr) first_lead <= 1'b0;

      if (state == S_LOAD)  bit_cnt <= '0;
      else if (sample_req)  bit_cnt <= last_bit ? '0 : bit_cnt + CW'(1);
      if (sample_req)       rx_shift <= {rx_shift[REG_WIDTH-2:0], mosi_cur};
      if (last_bit) begin
        rx_data   <= {rx_shift[REG_WIDTH-2:0], mosi_cur};
        word_done <= 1'b1;
      end

      rx_valid    <= last_bit;
      tx_underrun <= load_req && !buf_full;
      frame_err   <= err_req;

      if (tx_valid && !buf_full) begin
        buf_data <= tx_data;
        buf_full <= 1'b1;
      end else if (load_req) begin
        buf_full <= 1'b0;
      end
    end
  end

  assign SPI_MISO    = tx_shift[REG_WIDTH-1];
  assign SPI_MISO_OE = (state != S_IDLE);
  assign tx_ready    = !buf_full;

endmodule

// File: tb/tb_spi_slave_core.sv
// Directed bench for spi_slave_core: one instance per SPI mode, each driven by a
// bit-banged master task, with pulse counters watching the one-cycle strobes.
`timescale 1ns/1ps
module tb_spi_slave_core;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cs_n        [4];
  logic         sclk        [4];
  logic         mosi        [4];
  logic         miso        [4];
  logic         miso_oe     [4];
  logic         tx_valid    [4];
  logic         tx_ready    [4];
  logic         rx_valid    [4];
  logic         tx_underrun [4];
  logic         frame_err   [4];
  logic [W-1:0] tx_data     [4];
  logic [W-1:0] rx_data     [4];

  int errors = 0;
  int checks = 0;
  int rxv_cnt  [4] = '{0, 0, 0, 0};
  int unr_cnt  [4] = '{0, 0, 0, 0};
  int ferr_cnt [4] = '{0, 0, 0, 0};

  always #5 clk = ~clk;

  // Instance g runs SPI mode g: CPOL = g/2, CPHA = g%2.
  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_slave_core #(
      .REG_WIDTH(W), .CPOL(g / 2), .CPHA(g % 2), .SYNC_STAGES(2)
    ) dut (
      .clk(clk), .rst_n(rst_n),
      .SPI_CS_N(cs_n[g]), .SPI_SCLK(sclk[g]), .SPI_MOSI(mosi[g]),
      .SPI_MISO(miso[g]), .SPI_MISO_OE(miso_oe[g]),
      .tx_data(tx_data[g]), .tx_valid(tx_valid[g]), .tx_ready(tx_ready[g]),
      .rx_data(rx_data[g]), .rx_valid(rx_valid[g]),
      .tx_underrun(tx_underrun[g]), .frame_err(frame_err[g])
    );
  end

  // Strobe counters; the directed sequence compares deltas of these.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rx_valid[i])    rxv_cnt[i]++;
      if (tx_underrun[i]) unr_cnt[i]++;
      if (frame_err[i])   ferr_cnt[i]++;
    end
  end

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic halfWait();
    repeat (8) @(negedge clk);
  endtask

  // Bit-banged master: n bits from tx MSB first, MISO bits collected into rx.
  task automatic applyStimulus(input int m, input int n, input logic [W-1:0] tx,
                               output logic [W-1:0] rx);
    logic cpol, cpha;
    cpol = (m >= 2);
    cpha = (m % 2 == 1);
    rx   = '0;
    for (int i = 0; i < n; i++) begin
      if (!cpha) begin
        mosi[m] = tx[W-1-i];
        halfWait();
        sclk[m] = ~cpol;
        rx      = {rx[W-2:0], miso[m]};
        halfWait();
        sclk[m] = cpol;
      end else begin
        sclk[m] = ~cpol;
        mosi[m] = tx[W-1-i];
        halfWait();
        sclk[m] = cpol;
        rx      = {rx[W-2:0], miso[m]};
        halfWait();
      end
    end
  endtask

  task automatic csLow(input int m);
    cs_n[m] = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic csHigh(input int m);
    halfWait();
    cs_n[m] = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic loadTx(input int m, input logic [W-1:0] w);
    int n = 0;
    while (!tx_ready[m] && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput($sformatf("m%0d_tx_ready_before_load", m), 32'(tx_ready[m]), 32'd1);
    tx_data[m]  = w;
    tx_valid[m] = 1'b1;
    @(negedge clk);
    tx_valid[m] = 1'b0;
    checkOutput($sformatf("m%0d_tx_ready_after_load", m), 32'(tx_ready[m]), 32'd0);
  endtask

  initial begin
    logic [W-1:0] got;
    int rb, ub, fb;

    // Idle pins, reset asserted.
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cs_n[i]     = 1'b1;
      sclk[i]     = (i >= 2);
      mosi[i]     = 1'b0;
      tx_valid[i] = 1'b0;
      tx_data[i]  = '0;
    end
    repeat (4) @(negedge clk);
    checkOutput("rst_miso",        32'(miso[3]),        32'd0);
    checkOutput("rst_miso_oe",     32'(miso_oe[3]),     32'd0);
    checkOutput("rst_tx_ready",    32'(tx_ready[3]),    32'd1);
    checkOutput("rst_rx_data",     32'(rx_data[3]),     32'd0);
    checkOutput("rst_rx_valid",    32'(rx_valid[3]),    32'd0);
    checkOutput("rst_tx_underrun", 32'(tx_underrun[3]), 32'd0);
    checkOutput("rst_frame_err",   32'(frame_err[3]),   32'd0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    $display("[TB] mode 3 single word");
    loadTx(3, 16'hA5C3);
    rb = rxv_cnt[3];
    csLow(3);
    checkOutput("m3_oe_in_frame",       32'(miso_oe[3]),  32'd1);
    checkOutput("m3_tx_ready_after_ld", 32'(tx_ready[3]), 32'd1);
    applyStimulus(3, 16, 16'h1234, got);
    csHigh(3);
    checkOutput("m3_miso_word",   32'(got),              32'hA5C3);
    checkOutput("m3_rx_data",     32'(rx_data[3]),       32'h1234);
    checkOutput("m3_rx_valid_n",  32'(rxv_cnt[3] - rb),  32'd1);
    checkOutput("m3_oe_after_cs", 32'(miso_oe[3]),       32'd0);

    for (int m = 0; m < 3; m++) begin
      $display("[TB] mode %0d single word", m);
      checkOutput($sformatf("m%0d_oe_idle", m), 32'(miso_oe[m]), 32'd0);
      loadTx(m, 16'h7FFE);
      rb = rxv_cnt[m];
      csLow(m);
      applyStimulus(m, 16, 16'h8001, got);
      csHigh(m);
      checkOutput($sformatf("m%0d_miso_word", m),  32'(got),             32'h7FFE);
      checkOutput($sformatf("m%0d_rx_data", m),    32'(rx_data[m]),      32'h8001);
      checkOutput($sformatf("m%0d_rx_valid_n", m), 32'(rxv_cnt[m] - rb), 32'd1);
      checkOutput($sformatf("m%0d_oe_after", m),   32'(miso_oe[m]),      32'd0);
    end

    $display("[TB] mode 3 back-to-back words");
    loadTx(3, 16'h1111);
    rb = rxv_cnt[3];
    ub = unr_cnt[3];
    csLow(3);
    loadTx(3, 16'h2222);
    applyStimulus(3, 16, 16'hAAAA, got);
    checkOutput("b2b_miso_w0",    32'(got),        32'h1111);
    checkOutput("b2b_rx_data_w0", 32'(rx_data[3]), 32'hAAAA);
    applyStimulus(3, 16, 16'h5555, got);
    checkOutput("b2b_miso_w1",    32'(got),        32'h2222);
    checkOutput("b2b_rx_data_w1", 32'(rx_data[3]), 32'h5555);
    csHigh(3);
    checkOutput("b2b_rx_valid_n", 32'(rxv_cnt[3] - rb), 32'd2);
    checkOutput("b2b_underrun_n", 32'(unr_cnt[3] - ub), 32'd0);

    $display("[TB] mode 3 empty buffer");
    rb = rxv_cnt[3];
    ub = unr_cnt[3];
    csLow(3);
    applyStimulus(3, 16, 16'h3C5A, got);
    csHigh(3);
    checkOutput("unr_miso_zero",  32'(got),              32'h0000);
    checkOutput("unr_pulse_n",    32'(unr_cnt[3] - ub),  32'd1);
    checkOutput("unr_rx_data",    32'(rx_data[3]),       32'h3C5A);
    checkOutput("unr_rx_valid_n", 32'(rxv_cnt[3] - rb),  32'd1);

    $display("[TB] mode 3 partial frame");
    rb = rxv_cnt[3];
    fb = ferr_cnt[3];
    csLow(3);
    applyStimulus(3, 7, 16'hD5A0, got);
    csHigh(3);
    checkOutput("ferr_pulse_n",    32'(ferr_cnt[3] - fb), 32'd1);
    checkOutput("ferr_rx_valid_n", 32'(rxv_cnt[3] - rb),  32'd0);
    checkOutput("ferr_rx_data",    32'(rx_data[3]),       32'h3C5A);
    rb = rxv_cnt[3];
    csLow(3);
    applyStimulus(3, 16, 16'hBEEF, got);
    csHigh(3);
    checkOutput("ferr_next_rx_data", 32'(rx_data[3]),      32'hBEEF);
    checkOutput("ferr_next_valid_n", 32'(rxv_cnt[3] - rb), 32'd1);

    $display("[TB] mode 3 reset during frame");
    csLow(3);
    applyStimulus(3, 5, 16'hF800, got);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("midrst_rx_data", 32'(rx_data[3]), 32'd0);
    rst_n = 1'b1;
    rb = rxv_cnt[3];
    fb = ferr_cnt[3];
    repeat (4) @(negedge clk);
    checkOutput("midrst_oe_ignored", 32'(miso_oe[3]), 32'd0);
    applyStimulus(3, 11, 16'h0000, got);
    csHigh(3);
    checkOutput("midrst_rx_valid_n",  32'(rxv_cnt[3] - rb),  32'd0);
    checkOutput("midrst_frame_err_n", 32'(ferr_cnt[3] - fb), 32'd0);
    rb = rxv_cnt[3];
    csLow(3);
    applyStimulus(3, 16, 16'h0F0F, got);
    csHigh(3);
    checkOutput("midrst_next_rx_data", 32'(rx_data[3]),      32'h0F0F);
    checkOutput("midrst_next_valid_n", 32'(rxv_cnt[3] - rb), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
